// File: rtl/pcie_link_pm_ctrl_if.sv
// ASPM power-management signal bundle between the LTSSM/DLL side
// and the ASPM sequencer.
interface pcie_link_pm_ctrl_if;
    logic       ltssm_link_up;
    logic       ltssm_in_l0;
    logic       l0s_enable;
    logic       l1_enable;
    logic       tx_idle;
    logic       rx_elec_idle;
    logic       l1_ack;
    logic       l0s_entry;
    logic       l1_req;
    logic       pm_exit;
    logic       tx_elec_idle;
    logic [2:0] pm_state;
    logic       l1_timeout_err;
    logic       exit_timeout_err;

    modport master (
        output ltssm_link_up, ltssm_in_l0, l0s_enable, l1_enable,
        output tx_idle, rx_elec_idle, l1_ack,
        input  l0s_entry, l1_req, pm_exit, tx_elec_idle, pm_state,
        input  l1_timeout_err, exit_timeout_err
    );

    modport slave (
        input  ltssm_link_up, ltssm_in_l0, l0s_enable, l1_enable,
        input  tx_idle, rx_elec_idle, l1_ack,
        output l0s_entry, l1_req, pm_exit, tx_elec_idle, pm_state,
        output l1_timeout_err, exit_timeout_err
    );
endinterface

// File: rtl/pcie_link_pm_ctrl.sv
// ASPM sequencer: watches link idleness, requests L0s/L1 entry,
// handshakes L1 with the DLL and pulses the LTSSM on exit.
module pcie_link_pm_ctrl #(
    parameter int L0S_IDLE_CYCLES = 64,
    parameter int L1_IDLE_CYCLES  = 1024,
    parameter int L1_ACK_TIMEOUT  = 256,
    parameter int EXIT_TIMEOUT    = 512
) (
    input  logic               clk,
    input  logic               reset_n,
    pcie_link_pm_ctrl_if.slave pm
);
    localparam int IW = $clog2(L1_IDLE_CYCLES + 1);
    localparam int AW = (L1_ACK_TIMEOUT > 1) ? $clog2(L1_ACK_TIMEOUT) : 1;
    localparam int EW = (EXIT_TIMEOUT > 1) ? $clog2(EXIT_TIMEOUT) : 1;

    localparam logic [IW-1:0] L0S_LAST  = IW'(L0S_IDLE_CYCLES - 1);
    localparam logic [IW-1:0] L1_LAST   = IW'(L1_IDLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(L1_IDLE_CYCLES);
    localparam logic [AW-1:0] ACK_LAST  = AW'(L1_ACK_TIMEOUT - 1);
    localparam logic [EW-1:0] EXIT_LAST = EW'(EXIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        ACTIVE = 3'd1,
        L0S    = 3'd2,
        L1_REQ = 3'd3,
        L1     = 3'd4,
        EXIT   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idle_cnt;
    logic [AW-1:0] ack_cnt;
    logic [EW-1:0] exit_cnt;

    logic idle;
    logic l1_hit;
    logic l0s_hit;
    logic ack_to;
    logic exit_to;
    logic idle_clr;
    logic idle_run;

    assign idle    = pm.tx_idle && pm.rx_elec_idle;
    assign l1_hit  = pm.l1_enable && idle && (idle_cnt == L1_LAST);
    assign l0s_hit = pm.l0s_enable && idle && (idle_cnt == L0S_LAST);
    assign ack_to  = (ack_cnt == ACK_LAST);
    assign exit_to = (exit_cnt == EXIT_LAST);

    // L1 is tested before L0s so equal thresholds go straight to L1_REQ.
    always_comb begin
        state_nxt = state;
        if (!pm.ltssm_link_up) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF: state_nxt = ACTIVE;
                ACTIVE: begin
                    if (l1_hit)       state_nxt = L1_REQ;
                    else if (l0s_hit) state_nxt = L0S;
                end
                L0S: begin
                    if (!idle)       state_nxt = EXIT;
                    else if (l1_hit) state_nxt = L1_REQ;
                end
                L1_REQ: begin
                    if (pm.l1_ack)        state_nxt = L1;
                    else if (!pm.tx_idle) state_nxt = ACTIVE;
                    else if (ack_to)      state_nxt = ACTIVE;
                end
                L1: begin
                    if (!idle) state_nxt = EXIT;
                end
                EXIT: begin
                    if (pm.ltssm_in_l0) state_nxt = ACTIVE;
                    else if (exit_to)   state_nxt = ACTIVE;
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    assign idle_clr = (state_nxt == OFF)
                   || (state_nxt == ACTIVE && state != ACTIVE);
    assign idle_run = (state == ACTIVE) || (state == L0S);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= OFF;
            idle_cnt            <= '0;
            ack_cnt             <= '0;
            exit_cnt            <= '0;
            pm.pm_state         <= 3'd0;
            pm.l0s_entry        <= 1'b0;
            pm.l1_req           <= 1'b0;
            pm.pm_exit          <= 1'b0;
            pm.tx_elec_idle     <= 1'b0;
            pm.l1_timeout_err   <= 1'b0;
            pm.exit_timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pm.pm_state <= state_nxt;

            if (idle_clr) begin
                idle_cnt <= '0;
            end else if (idle_run) begin
                if (!idle)
                    idle_cnt <= '0;
                else if (idle_cnt != IDLE_MAX)
                    idle_cnt <= idle_cnt + IW'(1);
            end

            if (state == L1_REQ && state_nxt == L1_REQ)
                ack_cnt <= ack_cnt + AW'(1);
            else
                ack_cnt <= '0;

            if (state == EXIT && state_nxt == EXIT)
                exit_cnt <= exit_cnt + EW'(1);
            else
                exit_cnt <= '0;

            pm.l1_req       <= (state_nxt == L1_REQ);
            pm.tx_elec_idle <= (state_nxt == L0S) || (state_nxt == L1);
            pm.l0s_entry    <= (state == ACTIVE) && (state_nxt == L0S);
            pm.pm_exit      <= (state != EXIT) && (state_nxt == EXIT);

            // An abort on !tx_idle leaves L1_REQ without flagging an error.
            pm.l1_timeout_err <= (state == L1_REQ)
                              && (state_nxt == ACTIVE) && pm.tx_idle;
            pm.exit_timeout_err <= (state == EXIT)
                                && (state_nxt == ACTIVE) && !pm.ltssm_in_l0;
        end
    end
endmodule
